// File: rtl/ibex_alu.sv
// RV32I integer ALU: shared 33-bit adder, logic, shift and compare units.
// Result and compare flags are registered; adder outputs stay combinational.

package ibex_pkg;

    typedef enum integer {
        RV32BNone,
        RV32BBalanced,
        RV32BOTEarlGrey,
        RV32BFull
    } rv32b_e;

    typedef enum logic [6:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_XOR,
        ALU_OR,
        ALU_AND,
        ALU_XNOR,
        ALU_ORN,
        ALU_ANDN,
        ALU_SRA,
        ALU_SRL,
        ALU_SLL,
        ALU_ROR,
        ALU_ROL,
        ALU_LT,
        ALU_LTU,
        ALU_GE,
        ALU_GEU,
        ALU_EQ,
        ALU_NE,
        ALU_MIN,
        ALU_MINU,
        ALU_MAX,
        ALU_MAXU,
        ALU_SLT,
        ALU_SLTU,
        ALU_CLZ,
        ALU_CTZ,
        ALU_CPOP
    } alu_op_e;

endpackage

module ibex_alu
    import ibex_pkg::*;
#(
    parameter rv32b_e RV32B = RV32BNone
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  alu_op_e           operator_i,
    input  logic [31:0]       operand_a_i,
    input  logic [31:0]       operand_b_i,
    input  logic              instr_first_cycle_i,
    input  logic [32:0]       multdiv_operand_a_i,
    input  logic [32:0]       multdiv_operand_b_i,
    input  logic              multdiv_sel_i,
    input  logic [31:0]       imd_val_q_i [2],
    output logic [31:0]       imd_val_d_o [2],
    output logic [1:0]        imd_val_we_o,
    output logic [31:0]       adder_result_o,
    output logic [33:0]       adder_result_ext_o,
    output logic [31:0]       result_o,
    output logic              comparison_result_o,
    output logic              is_equal_result_o
);

    localparam bit unused_rv32b = (RV32B != RV32BNone);

    logic unused_inputs;
    assign unused_inputs = ^{instr_first_cycle_i, imd_val_q_i[0], imd_val_q_i[1]};

    for (genvar gi = 0; gi < 2; gi++) begin : g_imd_tie
        assign imd_val_d_o[gi]  = '0;
        assign imd_val_we_o[gi] = 1'b0;
    end

    logic        negate_b;
    logic        is_signed_cmp;
    logic [32:0] adder_in_a;
    logic [32:0] adder_in_b;

    always_comb begin
        negate_b      = 1'b0;
        is_signed_cmp = 1'b0;
        unique case (operator_i)
            ALU_SUB, ALU_EQ, ALU_NE, ALU_LTU, ALU_GEU, ALU_SLTU: negate_b = 1'b1;
            ALU_LT, ALU_GE, ALU_SLT: begin
                negate_b      = 1'b1;
                is_signed_cmp = 1'b1;
            end
            default: ;
        endcase
    end

    // The extra LSB carries the +1 of the two's complement negation.
    always_comb begin
        if (multdiv_sel_i) begin
            adder_in_a = multdiv_operand_a_i;
            adder_in_b = multdiv_operand_b_i;
        end else begin
            adder_in_a = {operand_a_i, 1'b1};
            adder_in_b = negate_b ? {~operand_b_i, 1'b1} : {operand_b_i, 1'b0};
        end
    end

    assign adder_result_ext_o = {1'b0, adder_in_a} + {1'b0, adder_in_b};
    assign adder_result_o     = adder_result_ext_o[32:1];

    logic [31:0] logic_result;
    always_comb begin
        logic_result = '0;
        unique case (operator_i)
            ALU_XOR: logic_result = operand_a_i ^ operand_b_i;
            ALU_OR:  logic_result = operand_a_i | operand_b_i;
            ALU_AND: logic_result = operand_a_i & operand_b_i;
            default: ;
        endcase
    end

    logic [4:0]  shamt;
    logic [31:0] shift_result;
    assign shamt = operand_b_i[4:0];

    always_comb begin
        shift_result = '0;
        unique case (operator_i)
            ALU_SLL: shift_result = operand_a_i << shamt;
            ALU_SRL: shift_result = operand_a_i >> shamt;
            ALU_SRA: shift_result = $unsigned($signed(operand_a_i) >>> shamt);
            default: ;
        endcase
    end

    logic is_equal;
    logic lt;
    logic cmp_result;

    assign is_equal = (operand_a_i == operand_b_i);

    // With equal MSBs a-b cannot overflow, so bit 32 is the difference sign.
    always_comb begin
        if (operand_a_i[31] != operand_b_i[31]) begin
            lt = is_signed_cmp ? operand_a_i[31] : operand_b_i[31];
        end else begin
            lt = adder_result_ext_o[32];
        end
    end

    always_comb begin
        cmp_result = 1'b0;
        unique case (operator_i)
            ALU_EQ:                             cmp_result = is_equal;
            ALU_NE:                             cmp_result = ~is_equal;
            ALU_LT, ALU_LTU, ALU_SLT, ALU_SLTU: cmp_result = lt;
            ALU_GE, ALU_GEU:                    cmp_result = ~lt;
            default: ;
        endcase
    end

    logic [31:0] result_d;
    always_comb begin
        result_d = '0;
        unique case (operator_i)
            ALU_ADD, ALU_SUB:          result_d = adder_result_o;
            ALU_XOR, ALU_OR, ALU_AND:  result_d = logic_result;
            ALU_SLL, ALU_SRL, ALU_SRA: result_d = shift_result;
            ALU_EQ, ALU_NE, ALU_LT, ALU_LTU, ALU_GE, ALU_GEU, ALU_SLT, ALU_SLTU:
                result_d = {31'b0, cmp_result};
            default: ;
        endcase
    end

    logic [31:0] result_q;
    logic        cmp_q;
    logic        eq_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            result_q <= '0;
            cmp_q    <= 1'b0;
            eq_q     <= 1'b0;
        end else begin
            result_q <= result_d;
            cmp_q    <= cmp_result;
            eq_q     <= is_equal;
        end
    end

    assign result_o            = result_q;
    assign comparison_result_o = cmp_q;
    assign is_equal_result_o   = eq_q;

endmodule

// File: tb/tb_ibex_alu.sv
// Self-checking bench for ibex_alu: directed cases from the test plan plus
// randomized operations compared against an arithmetic reference model.
module tb_ibex_alu;
    import ibex_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    alu_op_e     operator_i;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic        instr_first_cycle_i;
    logic [32:0] multdiv_operand_a_i;
    logic [32:0] multdiv_operand_b_i;
    logic        multdiv_sel_i;
    logic [31:0] imd_val_q_i [2];
    logic [31:0] imd_val_d_o [2];
    logic [1:0]  imd_val_we_o;
    logic [31:0] adder_result_o;
    logic [33:0] adder_result_ext_o;
    logic [31:0] result_o;
    logic        comparison_result_o;
    logic        is_equal_result_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    ibex_alu #(.RV32B(RV32BNone)) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .operator_i          (operator_i),
        .operand_a_i         (operand_a_i),
        .operand_b_i         (operand_b_i),
        .instr_first_cycle_i (instr_first_cycle_i),
        .multdiv_operand_a_i (multdiv_operand_a_i),
        .multdiv_operand_b_i (multdiv_operand_b_i),
        .multdiv_sel_i       (multdiv_sel_i),
        .imd_val_q_i         (imd_val_q_i),
        .imd_val_d_o         (imd_val_d_o),
        .imd_val_we_o        (imd_val_we_o),
        .adder_result_o      (adder_result_o),
        .adder_result_ext_o  (adder_result_ext_o),
        .result_o            (result_o),
        .comparison_result_o (comparison_result_o),
        .is_equal_result_o   (is_equal_result_o)
    );

    function automatic bit is_sub_like(alu_op_e op);
        return op inside {ALU_SUB, ALU_EQ, ALU_NE, ALU_LT, ALU_LTU, ALU_GE,
                          ALU_GEU, ALU_SLT, ALU_SLTU};
    endfunction

    function automatic logic [31:0] ref_adder(alu_op_e op, logic [31:0] a, logic [31:0] b);
        return is_sub_like(op) ? a - b : a + b;
    endfunction

    function automatic logic ref_cmp(alu_op_e op, logic [31:0] a, logic [31:0] b);
        case (op)
            ALU_EQ:            return a == b;
            ALU_NE:            return a != b;
            ALU_LT, ALU_SLT:   return $signed(a) < $signed(b);
            ALU_LTU, ALU_SLTU: return a < b;
            ALU_GE:            return $signed(a) >= $signed(b);
            ALU_GEU:           return a >= b;
            default:           return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_result(alu_op_e op, logic [31:0] a, logic [31:0] b);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_XOR: return a ^ b;
            ALU_OR:  return a | b;
            ALU_AND: return a & b;
            ALU_SLL: return a << b[4:0];
            ALU_SRL: return a >> b[4:0];
            ALU_SRA: return $unsigned($signed(a) >>> b[4:0]);
            ALU_EQ, ALU_NE, ALU_LT, ALU_LTU, ALU_GE, ALU_GEU, ALU_SLT, ALU_SLTU:
                return {31'b0, ref_cmp(op, a, b)};
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk_i);
        operator_i  = op;
        operand_a_i = a;
        operand_b_i = b;
        #1;
        chk($sformatf("%s adder", op.name()), {2'b0, adder_result_o}, {2'b0, ref_adder(op, a, b)});
        @(posedge clk_i);
        #1;
        chk($sformatf("%s result a=%h b=%h", op.name(), a, b), {2'b0, result_o},
            {2'b0, ref_result(op, a, b)});
        chk($sformatf("%s cmp", op.name()), {33'b0, comparison_result_o}, {33'b0, ref_cmp(op, a, b)});
        chk($sformatf("%s eq", op.name()), {33'b0, is_equal_result_o}, {33'b0, a == b});
        $display("op=%s a=%h b=%h result=%h cmp=%b eq=%b", op.name(), a, b, result_o,
                 comparison_result_o, is_equal_result_o);
    endtask

    alu_op_e ops [20] = '{ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND, ALU_SRA, ALU_SRL,
                          ALU_SLL, ALU_LT, ALU_LTU, ALU_GE, ALU_GEU, ALU_EQ, ALU_NE,
                          ALU_SLT, ALU_SLTU, ALU_XNOR, ALU_ROR, ALU_MIN, ALU_CLZ};

    initial begin
        rst_ni              = 1'b0;
        operator_i          = ALU_ADD;
        operand_a_i         = 32'd5;
        operand_b_i         = 32'd7;
        instr_first_cycle_i = 1'b0;
        multdiv_operand_a_i = '0;
        multdiv_operand_b_i = '0;
        multdiv_sel_i       = 1'b0;
        imd_val_q_i[0]      = '0;
        imd_val_q_i[1]      = '0;

        repeat (3) @(posedge clk_i);
        #1;
        chk("reset result", {2'b0, result_o}, 34'd0);
        chk("reset cmp", {33'b0, comparison_result_o}, 34'd0);
        chk("reset eq", {33'b0, is_equal_result_o}, 34'd0);
        chk("reset adder", {2'b0, adder_result_o}, 34'd12);
        chk("reset imd_we", {32'b0, imd_val_we_o}, 34'd0);
        $display("reset: result=%h adder=%h", result_o, adder_result_o);

        @(negedge clk_i);
        rst_ni = 1'b1;

        run_op(ALU_ADD, 32'd20, 32'd20);
        run_op(ALU_SUB, 32'd3, 32'd5);
        run_op(ALU_SUB, 32'd17, 32'd4);
        run_op(ALU_OR, 32'd12, 32'd3);
        run_op(ALU_AND, 32'd12, 32'd20);
        run_op(ALU_XOR, 32'hF0, 32'hFF);
        run_op(ALU_EQ, 32'd9, 32'd9);
        run_op(ALU_EQ, 32'd9, 32'd10);
        run_op(ALU_LT, 32'hFFFF_FFFF, 32'd1);
        run_op(ALU_LTU, 32'hFFFF_FFFF, 32'd1);
        run_op(ALU_GE, 32'h8000_0000, 32'h7FFF_FFFF);
        run_op(ALU_GEU, 32'h8000_0000, 32'h7FFF_FFFF);
        run_op(ALU_SRA, 32'h8000_0000, 32'h24);
        run_op(ALU_SLL, 32'd1, 32'd31);
        run_op(ALU_SRL, 32'h8000_0000, 32'h3F);
        run_op(ALU_XNOR, 32'h1234_5678, 32'h0F0F_0F0F);

        // Async reset between edges must clear the registered outputs at once.
        run_op(ALU_ADD, 32'd20, 32'd20);
        @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        chk("midreset result", {2'b0, result_o}, 34'd0);
        $display("mid-op reset: result=%h", result_o);
        @(negedge clk_i);
        rst_ni = 1'b1;
        run_op(ALU_ADD, 32'd1, 32'd2);

        @(negedge clk_i);
        operator_i          = ALU_ADD;
        multdiv_sel_i       = 1'b1;
        multdiv_operand_a_i = 33'h1_0000_0001;
        multdiv_operand_b_i = 33'h0_0000_0001;
        #1;
        chk("multdiv ext", adder_result_ext_o, 34'h1_0000_0002);
        chk("multdiv adder", {2'b0, adder_result_o}, 34'h8000_0001);
        @(posedge clk_i);
        #1;
        chk("multdiv result", {2'b0, result_o}, 34'h8000_0001);
        $display("multdiv: ext=%h result=%h", adder_result_ext_o, result_o);
        @(negedge clk_i);
        multdiv_sel_i = 1'b0;

        for (int i = 0; i < 200; i++) begin
            logic [31:0] ra;
            logic [31:0] rb;
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            if ($urandom_range(0, 5) == 0) ra[31] = ~rb[31];
            run_op(ops[$urandom_range(0, 19)], ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
